// File: rtl/add64_seq_pkg.sv
// Shared types and sizing helpers for the 64-bit adder operand sequencer.
package add64_seq_pkg;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    SETTLE,
    RESULT
  } state_t;

  function automatic int beats_f(input int word_w);
    return DATA_W / word_w;
  endfunction

  // Slot index width; a single-beat bus still needs a 1-bit index.
  function automatic int idx_w_f(input int word_w);
    return (beats_f(word_w) > 1) ? $clog2(beats_f(word_w)) : 1;
  endfunction

endpackage

// File: rtl/add64_operand_sequencer_if.sv
// Beat input, adder-side and result signals of the operand sequencer.
// Optional res_ovf appears when ADD64_SEQ_OVF_EN is defined.
interface add64_operand_sequencer_if
  import add64_seq_pkg::*;
#(
  parameter int WORD_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_cin;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              op_cin;
  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_sum;
  logic              res_cout;
`ifdef ADD64_SEQ_OVF_EN
  logic              res_ovf;
`endif

  // master: the sequencer itself; slave: producer, adder and consumer side.
  modport master (
`ifdef ADD64_SEQ_OVF_EN
    output res_ovf,
`endif
    input  in_valid, in_data, in_cin, add_sum, add_cout, res_ready,
    output in_ready, op_a, op_b, op_cin, res_valid, res_sum, res_cout
  );

  modport slave (
`ifdef ADD64_SEQ_OVF_EN
    input  res_ovf,
`endif
    output in_valid, in_data, in_cin, add_sum, add_cout, res_ready,
    input  in_ready, op_a, op_b, op_cin, res_valid, res_sum, res_cout
  );

endinterface

// File: rtl/add64_beat_packer.sv
// 64-bit operand register written one WORD_W slot at a time, with synchronous clear.
module add64_beat_packer
  import add64_seq_pkg::*;
#(
  parameter  int WORD_W = 16,
  localparam int IDX_W  = idx_w_f(WORD_W)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (we) begin
      q[idx*WORD_W +: WORD_W] <= din;
    end
  end

endmodule

// File: rtl/add64_operand_sequencer.sv
// Assembles two 64-bit operands from a narrow beat stream, holds them for the external
// ripple adder to settle, then captures Sum/Cout. Optional feature: ADD64_SEQ_OVF_EN.
module add64_operand_sequencer
  import add64_seq_pkg::*;
#(
  parameter int WORD_W        = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  add64_operand_sequencer_if.master bus
);

  localparam int               BEATS       = beats_f(WORD_W);
  localparam int               IDX_W       = idx_w_f(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BEATS - 1);
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic [3:0]        settle_cnt;
  logic              we_a, we_b, capture, in_ready, res_valid;
  logic [DATA_W-1:0] op_a, op_b;
  logic              op_cin;
  logic [DATA_W-1:0] res_sum;
  logic              res_cout;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;
    capture   = 1'b0;
    case (state)
      LOAD_A: begin
        in_ready = 1'b1;
        we_a     = bus.in_valid;
        if (we_a && cnt == LAST_IDX) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        we_b     = bus.in_valid;
        if (we_b && cnt == LAST_IDX) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = RESULT;
        end
      end
      RESULT: begin
        res_valid = 1'b1;
        if (bus.res_ready) state_nxt = LOAD_A;
      end
      default: state_nxt = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD_A;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      settle_cnt <= '0;
      op_cin     <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
    end else begin
      if (we_a || we_b) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
      // Carry-in belongs to the transaction, so only the closing B beat supplies it.
      if (we_b && cnt == LAST_IDX) begin
        op_cin     <= bus.in_cin;
        settle_cnt <= SETTLE_INIT;
      end else if (state == SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (capture) begin
        res_sum  <= bus.add_sum;
        res_cout <= bus.add_cout;
      end
    end
  end

  add64_beat_packer #(.WORD_W(WORD_W)) u_pack_a (
    .clk (clk),
    .clr (rst),
    .we  (we_a),
    .idx (cnt),
    .din (bus.in_data),
    .q   (op_a)
  );

  add64_beat_packer #(.WORD_W(WORD_W)) u_pack_b (
    .clk (clk),
    .clr (rst),
    .we  (we_b),
    .idx (cnt),
    .din (bus.in_data),
    .q   (op_b)
  );

`ifdef ADD64_SEQ_OVF_EN
  logic res_ovf;

  // Signed overflow: like-signed operands whose sum flips the sign.
  always_ff @(posedge clk) begin
    if (rst)          res_ovf <= 1'b0;
    else if (capture) res_ovf <= (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                                 (bus.add_sum[DATA_W-1] != op_a[DATA_W-1]);
  end

  assign bus.res_ovf = res_ovf;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.res_valid = res_valid;
  assign bus.op_a      = op_a;
  assign bus.op_b      = op_b;
  assign bus.op_cin    = op_cin;
  assign bus.res_sum   = res_sum;
  assign bus.res_cout  = res_cout;

endmodule

// File: tb/tb_add64_operand_sequencer.sv
// Bench for add64_operand_sequencer: behavioural adder, randomized beats/gaps, arithmetic reference model.
module tb_add64_operand_sequencer;

  localparam int WORD_W = 16;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  add64_operand_sequencer_if #(.WORD_W(WORD_W)) bus ();

  add64_operand_sequencer #(.WORD_W(WORD_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External ripple adder stand-in.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {64'd0, bus.op_cin};

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [WORD_W-1:0] w, input logic cin, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (gap) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = WORD_W'($urandom);
      bus.in_cin   = 1'($urandom);
    end
    @(negedge clk);
    chk1("in_ready_load", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bus.in_cin   = cin;
    @(posedge clk);
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] b, input logic cin, input int maxgap);
    for (int i = 0; i < 4; i++) beat(a[16*i +: 16], 1'($urandom), maxgap);
    for (int i = 0; i < 4; i++) beat(b[16*i +: 16], (i == 3) ? cin : 1'($urandom), maxgap);
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (bus.res_valid !== 1'b1 && lat < 50) begin
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input logic [63:0] a, input logic [63:0] b,
                              input logic cin);
    logic [64:0] exp;
    exp = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    chk64({tag, "_op_a"}, bus.op_a, a);
    chk64({tag, "_op_b"}, bus.op_b, b);
    chk1 ({tag, "_op_cin"}, bus.op_cin, cin);
    chk64({tag, "_sum"}, bus.res_sum, exp[63:0]);
    chk1 ({tag, "_cout"}, bus.res_cout, exp[64]);
    chk1 ({tag, "_valid"}, bus.res_valid, 1'b1);
    chk1 ({tag, "_in_ready_res"}, bus.in_ready, 1'b0);
`ifdef ADD64_SEQ_OVF_EN
    chk1 ({tag, "_ovf"}, bus.res_ovf, (a[63] == b[63]) && (exp[63] != a[63]));
`endif
  endtask

  task automatic accept(input string tag);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk1({tag, "_valid_after_acc"}, bus.res_valid, 1'b0);
    chk1({tag, "_in_ready_after_acc"}, bus.in_ready, 1'b1);
  endtask

  task automatic run_add(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic cin, input int maxgap);
    int lat;
    load(a, b, cin, maxgap);
    wait_result(lat);
    chk64({tag, "_latency"}, 64'(lat), 64'(SETTLE));
    check_result(tag, a, b, cin);
    accept(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    logic        cin;
    int          lat;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cin    = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk1 ("rst_in_ready", bus.in_ready, 1'b1);
    chk1 ("rst_res_valid", bus.res_valid, 1'b0);
    chk64("rst_op_a", bus.op_a, 64'd0);
    chk64("rst_res_sum", bus.res_sum, 64'd0);

    run_add("basic", 64'd1, 64'd1, 1'b0, 0);
    run_add("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 0);
    run_add("order_gaps", 64'h4444_3333_2222_1111, 64'd0, 1'b0, 3);

    for (int n = 0; n < 8; n++) begin
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
      run_add("random", a, b, cin, 2);
    end

    // Result held under backpressure while junk beats are offered.
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    load(a, b, 1'b1, 1);
    wait_result(lat);
    chk64("bp_latency", 64'(lat), 64'(SETTLE));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = WORD_W'($urandom);
      check_result("bp", a, b, 1'b1);
    end
    accept("bp");
    chk64("bp_op_a_kept", bus.op_a, a);

    // Reset in the middle of loading B.
    for (int i = 0; i < 4; i++) beat(16'hA5A5, 1'b1, 0);
    beat(16'h1234, 1'b1, 0);
    beat(16'h5678, 1'b1, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk1 ("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk1 ("mid_rst_res_valid", bus.res_valid, 1'b0);
    chk64("mid_rst_op_a", bus.op_a, 64'd0);
    chk64("mid_rst_op_b", bus.op_b, 64'd0);
    chk1 ("mid_rst_op_cin", bus.op_cin, 1'b0);
    chk64("mid_rst_res_sum", bus.res_sum, 64'd0);
    chk1 ("mid_rst_res_cout", bus.res_cout, 1'b0);
`ifdef ADD64_SEQ_OVF_EN
    chk1 ("mid_rst_ovf", bus.res_ovf, 1'b0);
`endif
    run_add("after_rst", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1);

`ifdef ADD64_SEQ_OVF_EN
    run_add("ovf_set", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0);
    chk1("ovf_set_flag", bus.res_ovf, 1'b1);
    run_add("ovf_clr", 64'd1, 64'd1, 1'b0, 0);
    chk1("ovf_clr_flag", bus.res_ovf, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
